// File: rtl/ins_fetch_pkg.sv
// Shared widths, opcodes, fetch states and the
// instruction classifier used by the fetch unit.
package ins_fetch_pkg;

    localparam int DAT_W     = 32;
    localparam int RAM_ADR_W = 32;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_BR   = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_JRWAIT,
        ST_DROP
    } fetch_state_t;

    typedef struct packed {
        logic                 ic;
        logic                 jmp;
        logic                 br;
        logic                 jr;
        logic [RAM_ADR_W-1:0] imm;
    } ins_cls_t;

    function automatic ins_cls_t classify(input logic [DAT_W-1:0] i);
        ins_cls_t c;
        logic     jal;
        logic     jalr;
        logic     br;
        logic     cj;
        logic     cb;
        logic     cjr;
        c     = '0;
        c.ic  = (i[1:0] != 2'b11);
        jal   = !c.ic && (i[6:0] == OPC_JAL);
        jalr  = !c.ic && (i[6:0] == OPC_JALR);
        br    = !c.ic && (i[6:0] == OPC_BR);
        cj    = (i[1:0] == 2'b01) &&
                ((i[15:13] == 3'b101) || (i[15:13] == 3'b001));
        cb    = (i[1:0] == 2'b01) && (i[15:14] == 2'b11);
        cjr   = (i[1:0] == 2'b10) && (i[15:13] == 3'b100) &&
                (i[11:7] != 5'd0) && (i[6:2] == 5'd0);
        c.jmp = jal | cj;
        c.br  = br | cb;
        c.jr  = jalr | cjr;
        unique case (1'b1)
            jal: c.imm = {{11{i[31]}}, i[31], i[19:12], i[20],
                          i[30:21], 1'b0};
            br:  c.imm = {{19{i[31]}}, i[31], i[7], i[30:25],
                          i[11:8], 1'b0};
            cj:  c.imm = {{20{i[12]}}, i[12], i[8], i[10:9], i[6],
                          i[7], i[2], i[11], i[5:3], 1'b0};
            cb:  c.imm = {{23{i[12]}}, i[12], i[6:5], i[2],
                          i[11:10], i[4:3], 1'b0};
            default: c.imm = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ins_fetch_bht.sv
// Branch history table: 2-bit saturating counters,
// combinational read, synchronous update.
module ins_fetch_bht
    import ins_fetch_pkg::*;
#(
    parameter int BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic                rd_tk,
    input  logic                up_en,
    input  logic [BHT_BITS-1:0] up_idx,
    input  logic                up_tk
);

    logic [1:0] cnt [2**BHT_BITS];

    assign rd_tk = cnt[rd_idx][1];

    // Reset all counters to weakly not-taken; saturate on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2**BHT_BITS; k++) begin
                cnt[k] <= 2'b01;
            end
        end else if (en && up_en) begin
            if (up_tk && (cnt[up_idx] != 2'b11)) begin
                cnt[up_idx] <= cnt[up_idx] + 2'b01;
            end else if (!up_tk && (cnt[up_idx] != 2'b00)) begin
                cnt[up_idx] <= cnt[up_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: PC, icache requests, next-PC
// prediction and single-beat hand-off to the decoder.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [RAM_ADR_W-1:0] RST_PC   = 32'h0,
    parameter int                   BHT_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 ic_en_o,
    output logic [RAM_ADR_W-1:0] ic_adr_o,
    input  logic                 ic_rdy_i,
    input  logic [DAT_W-1:0]     ic_ins_i,
    input  logic                 dec_full_i,
    output logic                 if_en_o,
    output logic                 if_ic_o,
    output logic [DAT_W-1:0]     if_ins_o,
    output logic [RAM_ADR_W-1:0] if_pc_o,
    output logic                 if_pbr_o,
    input  logic                 rob_clr_i,
    input  logic [RAM_ADR_W-1:0] rob_npc_i,
    input  logic                 rob_br_en_i,
    input  logic [RAM_ADR_W-1:0] rob_br_pc_i,
    input  logic                 rob_br_tk_i
);

    fetch_state_t         state;
    logic [RAM_ADR_W-1:0] pc;
    ins_cls_t             cls;
    logic                 bht_tk;
    logic [RAM_ADR_W-1:0] len;
    logic [RAM_ADR_W-1:0] npc;
    logic                 pbr;
    logic [DAT_W-1:0]     ins_n;

    logic                 hb_vld;
    logic                 hb_ic;
    logic                 hb_pbr;
    logic                 hb_jr;
    logic [DAT_W-1:0]     hb_ins;
    logic [RAM_ADR_W-1:0] hb_pc;

    ins_fetch_bht #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rd_idx (pc[BHT_BITS:1]),
        .rd_tk  (bht_tk),
        .up_en  (rob_br_en_i),
        .up_idx (rob_br_pc_i[BHT_BITS:1]),
        .up_tk  (rob_br_tk_i)
    );

    assign cls      = classify(ic_ins_i);
    assign ic_en_o  = !rst &&
                      ((state == ST_FETCH) || (state == ST_DROP));
    assign ic_adr_o = pc;

    // Predict the next PC from the word returned this cycle.
    always_comb begin
        len   = cls.ic ? RAM_ADR_W'(2) : RAM_ADR_W'(4);
        ins_n = cls.ic ? {16'h0, ic_ins_i[15:0]} : ic_ins_i;
        npc   = pc + len;
        pbr   = 1'b0;
        if (cls.jmp || (cls.br && bht_tk)) begin
            npc = pc + cls.imm;
            pbr = 1'b1;
        end
    end

    // Fetch state machine with registered decoder outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= RST_PC;
            if_en_o  <= 1'b0;
            if_ic_o  <= 1'b0;
            if_ins_o <= '0;
            if_pc_o  <= '0;
            if_pbr_o <= 1'b0;
            hb_vld   <= 1'b0;
            hb_ic    <= 1'b0;
            hb_pbr   <= 1'b0;
            hb_jr    <= 1'b0;
            hb_ins   <= '0;
            hb_pc    <= '0;
        end else if (en) begin
            if_en_o <= 1'b0;
            if (rob_clr_i) begin
                pc     <= rob_npc_i;
                hb_vld <= 1'b0;
                if (((state == ST_FETCH) || (state == ST_DROP)) &&
                    !ic_rdy_i) begin
                    state <= ST_DROP;
                end else begin
                    state <= ST_FETCH;
                end
            end else begin
                unique case (state)
                    ST_FETCH: begin
                        if (ic_rdy_i) begin
                            pc <= npc;
                            if (dec_full_i) begin
                                hb_vld <= 1'b1;
                                hb_ic  <= cls.ic;
                                hb_pbr <= pbr;
                                hb_jr  <= cls.jr;
                                hb_ins <= ins_n;
                                hb_pc  <= pc;
                                state  <= ST_HOLD;
                            end else begin
                                if_en_o  <= 1'b1;
                                if_ic_o  <= cls.ic;
                                if_ins_o <= ins_n;
                                if_pc_o  <= pc;
                                if_pbr_o <= pbr;
                                state    <= cls.jr ? ST_JRWAIT
                                                   : ST_FETCH;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!dec_full_i && hb_vld) begin
                            if_en_o  <= 1'b1;
                            if_ic_o  <= hb_ic;
                            if_ins_o <= hb_ins;
                            if_pc_o  <= hb_pc;
                            if_pbr_o <= hb_pbr;
                            hb_vld   <= 1'b0;
                            state    <= hb_jr ? ST_JRWAIT : ST_FETCH;
                        end
                    end
                    ST_JRWAIT: begin
                        state <= ST_JRWAIT;
                    end
                    ST_DROP: begin
                        if (ic_rdy_i) begin
                            state <= ST_FETCH;
                        end
                    end
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a behavioural
// reference model and per-cycle output comparison.
module tb_ins_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ic_en_o;
    logic [31:0] ic_adr_o;
    logic        ic_rdy_i;
    logic [31:0] ic_ins_i;
    logic        dec_full_i;
    logic        if_en_o;
    logic        if_ic_o;
    logic [31:0] if_ins_o;
    logic [31:0] if_pc_o;
    logic        if_pbr_o;
    logic        rob_clr_i;
    logic [31:0] rob_npc_i;
    logic        rob_br_en_i;
    logic [31:0] rob_br_pc_i;
    logic        rob_br_tk_i;

    int errors = 0;
    int checks = 0;

    ins_fetch #(
        .RST_PC   (32'h0),
        .BHT_BITS (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ic_en_o     (ic_en_o),
        .ic_adr_o    (ic_adr_o),
        .ic_rdy_i    (ic_rdy_i),
        .ic_ins_i    (ic_ins_i),
        .dec_full_i  (dec_full_i),
        .if_en_o     (if_en_o),
        .if_ic_o     (if_ic_o),
        .if_ins_o    (if_ins_o),
        .if_pc_o     (if_pc_o),
        .if_pbr_o    (if_pbr_o),
        .rob_clr_i   (rob_clr_i),
        .rob_npc_i   (rob_npc_i),
        .rob_br_en_i (rob_br_en_i),
        .rob_br_pc_i (rob_br_pc_i),
        .rob_br_tk_i (rob_br_tk_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        bit          c;
        bit          pbr;
        bit          jr;
    } item_t;

    int          cnt [64];
    item_t       hq [$];
    logic [31:0] m_pc;
    bit          m_jr;
    bit          m_drop;
    bit          e_en;
    bit          e_ic;
    bit          e_pbr;
    logic [31:0] e_ins;
    logic [31:0] e_pc;

    function automatic item_t predict(input logic [31:0] w,
                                      input logic [31:0] pc,
                                      output logic [31:0] nxt);
        item_t it;
        int    imm;
        bit    tk;
        it.pc  = pc;
        it.c   = (w[1:0] != 2'b11);
        it.ins = it.c ? (w & 32'h0000FFFF) : w;
        it.jr  = 0;
        tk     = 0;
        imm    = 0;
        if (!it.c) begin
            if (w[6:0] == 7'h6F) begin
                imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096
                    + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                tk = 1;
            end else if (w[6:0] == 7'h63) begin
                imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048
                    + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                tk = (cnt[(pc >> 1) & 63] >= 2);
            end else if (w[6:0] == 7'h67) begin
                it.jr = 1;
            end
        end else if (w[1:0] == 2'b01 &&
                     (w[15:13] == 3'd5 || w[15:13] == 3'd1)) begin
            imm = (w[12] ? -2048 : 0) + int'(w[8]) * 1024
                + int'(w[10:9]) * 256 + int'(w[6]) * 128
                + int'(w[7]) * 64 + int'(w[2]) * 32
                + int'(w[11]) * 16 + int'(w[5:3]) * 2;
            tk = 1;
        end else if (w[1:0] == 2'b01 && w[15:14] == 2'b11) begin
            imm = (w[12] ? -256 : 0) + int'(w[6:5]) * 64
                + int'(w[2]) * 32 + int'(w[11:10]) * 8
                + int'(w[4:3]) * 2;
            tk = (cnt[(pc >> 1) & 63] >= 2);
        end else if (w[1:0] == 2'b10 && w[15:13] == 3'd4 &&
                     w[11:7] != 0 && w[6:2] == 0) begin
            it.jr = 1;
        end
        it.pbr = tk;
        nxt = tk ? pc + 32'(imm) : pc + (it.c ? 32'd2 : 32'd4);
        return it;
    endfunction

    task automatic issue(input item_t it);
        e_en  = 1;
        e_ic  = it.c;
        e_ins = it.ins;
        e_pc  = it.pc;
        e_pbr = it.pbr;
    endtask

    // Advance the model on each rising edge using the same inputs.
    always @(posedge clk) begin
        item_t       it;
        logic [31:0] nxt;
        int          bi;
        if (rst) begin
            foreach (cnt[k]) cnt[k] = 1;
            hq.delete();
            m_pc = 0; m_jr = 0; m_drop = 0;
            e_en = 0; e_ic = 0; e_pbr = 0; e_ins = 0; e_pc = 0;
        end else if (en) begin
            e_en = 0;
            if (rob_clr_i) begin
                m_drop = (m_drop || (!m_jr && hq.size() == 0))
                         && !ic_rdy_i;
                m_jr = 0;
                hq.delete();
                m_pc = rob_npc_i;
            end else if (m_drop) begin
                if (ic_rdy_i) m_drop = 0;
            end else if (m_jr) begin
                m_jr = 1;
            end else if (hq.size() != 0) begin
                if (!dec_full_i) begin
                    issue(hq[0]);
                    m_jr = hq[0].jr;
                    hq.delete();
                end
            end else if (ic_rdy_i) begin
                it = predict(ic_ins_i, m_pc, nxt);
                m_pc = nxt;
                if (dec_full_i) begin
                    hq.push_back(it);
                end else begin
                    issue(it);
                    m_jr = it.jr;
                end
            end
            if (rob_br_en_i) begin
                bi = int'((rob_br_pc_i >> 1) & 32'd63);
                if (rob_br_tk_i && cnt[bi] < 3) cnt[bi]++;
                if (!rob_br_tk_i && cnt[bi] > 0) cnt[bi]--;
            end
        end
    end

    // Compare DUT outputs against the model after every edge.
    always @(posedge clk) begin
        bit exp_ic_en;
        #2;
        exp_ic_en = !rst && !m_jr && (hq.size() == 0);
        chk("if_en", 32'(if_en_o), 32'(e_en));
        if (e_en) begin
            chk("if_ic", 32'(if_ic_o), 32'(e_ic));
            chk("if_ins", if_ins_o, e_ins);
            chk("if_pc", if_pc_o, e_pc);
            chk("if_pbr", 32'(if_pbr_o), 32'(e_pbr));
        end
        chk("ic_en", 32'(ic_en_o), 32'(exp_ic_en));
        if (exp_ic_en) chk("ic_adr", ic_adr_o, m_pc);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic [31:0] w,
                       input logic f, input logic c,
                       input logic [31:0] n, input logic e);
        en          = e;
        ic_rdy_i    = r;
        ic_ins_i    = w;
        dec_full_i  = f;
        rob_clr_i   = c;
        rob_npc_i   = n;
        rob_br_en_i = 0;
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] w);
        cyc(1, w, 0, 0, 0, 1);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic redir(input logic [31:0] n, input logic r);
        cyc(r, 0, 0, 1, n, 1);
    endtask

    task automatic commit(input logic [31:0] p, input logic tk);
        en          = 1;
        ic_rdy_i    = 0;
        ic_ins_i    = 0;
        dec_full_i  = 0;
        rob_clr_i   = 0;
        rob_br_en_i = 1;
        rob_br_pc_i = p;
        rob_br_tk_i = tk;
        @(negedge clk);
        rob_br_en_i = 0;
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ  = 32'h00000863;

    initial begin
        rst = 1; en = 1; ic_rdy_i = 0; ic_ins_i = 0;
        dec_full_i = 0; rob_clr_i = 0; rob_npc_i = 0;
        rob_br_en_i = 0; rob_br_pc_i = 0; rob_br_tk_i = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        idle();
        chk("rst if_en", 32'(if_en_o), 0);
        chk("rst ic_en", 32'(ic_en_o), 1);
        chk("rst ic_adr", ic_adr_o, 0);

        feed(ADDI);
        chk("addi if_en", 32'(if_en_o), 1);
        chk("addi if_ic", 32'(if_ic_o), 0);
        chk("addi if_pc", if_pc_o, 0);
        chk("addi next", ic_adr_o, 32'h4);
        feed(32'h00100113);
        chk("pc8 adr", ic_adr_o, 32'h8);
        feed(32'hABCD4505);
        chk("cli if_ic", 32'(if_ic_o), 1);
        chk("cli if_ins", if_ins_o, 32'h00004505);
        chk("cli next", ic_adr_o, 32'hA);

        redir(32'h20, 1);
        chk("redir if_en", 32'(if_en_o), 0);
        feed(32'h0100006F);
        chk("jal pbr", 32'(if_pbr_o), 1);
        chk("jal next", ic_adr_o, 32'h30);
        redir(32'h40, 1);
        feed(32'h0000A011);
        chk("cj pbr", 32'(if_pbr_o), 1);
        chk("cj next", ic_adr_o, 32'h44);

        redir(32'h100, 1);
        feed(BEQ);
        chk("beq nt pbr", 32'(if_pbr_o), 0);
        chk("beq nt next", ic_adr_o, 32'h104);
        commit(32'h100, 1);
        commit(32'h100, 1);
        redir(32'h100, 1);
        feed(BEQ);
        chk("beq tk pbr", 32'(if_pbr_o), 1);
        chk("beq tk next", ic_adr_o, 32'h110);
        commit(32'h100, 1);
        commit(32'h100, 1);
        commit(32'h100, 0);
        redir(32'h100, 1);
        feed(BEQ);
        chk("beq sat pbr", 32'(if_pbr_o), 1);
        commit(32'h100, 0);
        redir(32'h100, 1);
        feed(BEQ);
        chk("beq dec pbr", 32'(if_pbr_o), 0);

        redir(32'h200, 1);
        feed(32'h00008067);
        chk("jalr if_en", 32'(if_en_o), 1);
        chk("jalr pbr", 32'(if_pbr_o), 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("jrwait ic_en", 32'(ic_en_o), 0);
        end
        redir(32'h300, 0);
        chk("jr clr ic_en", 32'(ic_en_o), 1);
        chk("jr clr adr", ic_adr_o, 32'h300);

        redir(32'h80, 0);
        chk("drop if_en", 32'(if_en_o), 0);
        idle();
        feed(ADDI);
        chk("drop disc", 32'(if_en_o), 0);
        chk("drop ic_en", 32'(ic_en_o), 1);
        chk("drop adr", ic_adr_o, 32'h80);
        feed(ADDI);
        chk("post drop pc", if_pc_o, 32'h80);

        cyc(1, 32'h00100113, 1, 0, 0, 1);
        chk("full if_en", 32'(if_en_o), 0);
        chk("hold ic_en", 32'(ic_en_o), 0);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        chk("full2 if_en", 32'(if_en_o), 0);
        idle();
        chk("hold issue", 32'(if_en_o), 1);
        chk("hold pc", if_pc_o, 32'h84);
        idle();
        chk("hold once", 32'(if_en_o), 0);
        chk("hold next", ic_adr_o, 32'h88);

        cyc(1, ADDI, 0, 0, 0, 0);
        chk("en0 if_en", 32'(if_en_o), 0);
        chk("en0 adr", ic_adr_o, 32'h88);

        redir(32'hFFFFFFFC, 1);
        feed(ADDI);
        chk("wrap pc", if_pc_o, 32'hFFFFFFFC);
        chk("wrap next", ic_adr_o, 32'h0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
